// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRP read ports, pending-write scoreboard and a post-reset clear sequence.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports and mask rd_busy with a port B write.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_done,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     clr_cnt_q;
    logic              init_done_q;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic              run_s;
    logic              clr_s;
    logic [NRP*XLEN-1:0] rd_data_s;
    logic [NRP-1:0]      rd_busy_s;

    // Reset is sampled combinationally so nothing leaks out during a mid-run reset cycle.
    always_comb begin
        run_s = (state_q == ST_RUN) && !reset;
        clr_s = (state_q == ST_INIT) && !reset;
    end

    // Sequencer: clear one register per cycle after reset, then run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= {AW{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
                    if (clr_cnt_q == AW'(NREG - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q     <= ST_INIT;
                        init_done_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q     <= ST_RUN;
                    clr_cnt_q   <= clr_cnt_q;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_INIT;
                    clr_cnt_q   <= {AW{1'b0}};
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = init_done_q;

    // Scoreboard next state: port B clears, a same-cycle set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        for (int n = 1; n < NREG; n++) begin
            if (run_s) begin
                busy_d[n] = (busy_q[n] & ~(wb_en && (wb_addr == AW'(n))))
                          | (busy_set_en && (busy_set_addr == AW'(n)));
            end else begin
                busy_d[n] = busy_q[n];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= {NREG{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Storage next state: clear sequence, else port B over port A.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            regs_d[n] = regs_q[n];
        end
        for (int n = 1; n < NREG; n++) begin
            if (clr_s && (clr_cnt_q == AW'(n))) begin
                regs_d[n] = {XLEN{1'b0}};
            end else if (run_s && wb_en && (wb_addr == AW'(n))) begin
                regs_d[n] = wb_data;
            end else if (run_s && wa_en && (wa_addr == AW'(n))) begin
                regs_d[n] = wa_data;
            end else begin
                regs_d[n] = regs_q[n];
            end
        end
        regs_d[0] = {XLEN{1'b0}};
    end

    // Storage is deliberately not reset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NREG; n++) begin
            regs_q[n] <= regs_d[n];
        end
    end

    // Read ports with optional same-cycle forwarding.
    always_comb begin
        rd_data_s = {(NRP*XLEN){1'b0}};
        rd_busy_s = {NRP{1'b0}};
        for (int i = 0; i < NRP; i++) begin
            logic [AW-1:0] addr_v;
            addr_v = rd_addr[i*AW +: AW];
            if (!run_s || (addr_v == {AW{1'b0}})) begin
                rd_data_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[i]              = 1'b0;
`ifdef RF_BYPASS_EN
            end else if (wb_en && (wb_addr == addr_v)) begin
                rd_data_s[i*XLEN +: XLEN] = wb_data;
                rd_busy_s[i]              = 1'b0;
            end else if (wa_en && (wa_addr == addr_v)) begin
                rd_data_s[i*XLEN +: XLEN] = wa_data;
                rd_busy_s[i]              = busy_q[addr_v];
`endif
            end else begin
                rd_data_s[i*XLEN +: XLEN] = regs_q[addr_v];
                rd_busy_s[i]              = busy_q[addr_v];
            end
        end
    end

    assign rd_data = rd_data_s;
    assign rd_busy = rd_busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural register-file model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = $clog2(NREG);
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                init_done;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wa_en = 1'b0;
    logic [AW-1:0]       wa_addr = '0;
    logic [XLEN-1:0]     wa_data = '0;
    logic                wb_en = 1'b0;
    logic [AW-1:0]       wb_addr = '0;
    logic [XLEN-1:0]     wb_data = '0;
    logic                busy_set_en = 1'b0;
    logic [AW-1:0]       busy_set_addr = '0;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
    );

    always #5 clk = ~clk;

    // Model: cycles since reset release gate the clear phase; plain array and bit vector hold state.
    logic [XLEN-1:0] mregs [NREG];
    logic [NREG-1:0] mbusy = '0;
    int              mcnt  = 0;
    logic            minit = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mcnt  <= 0;
            minit <= 1'b0;
            mbusy <= '0;
        end else if (mcnt < NREG) begin
            mregs[mcnt] <= '0;
            mcnt        <= mcnt + 1;
            minit       <= (mcnt == NREG - 1);
        end else begin
            minit <= 1'b1;
            if (wa_en && wa_addr != 0) mregs[wa_addr] <= wa_data;
            if (wb_en && wb_addr != 0) mregs[wb_addr] <= wb_data;
            if (wb_en) mbusy[wb_addr] <= 1'b0;
            if (busy_set_en && busy_set_addr != 0) mbusy[busy_set_addr] <= 1'b1;
        end
    end

    logic [AW-1:0]   ca;
    logic [XLEN-1:0] ed;
    logic            eb;
    logic            mrun;

    // Compare every output against the model, mid-cycle.
    always @(negedge clk) begin
        mrun = !reset && (mcnt >= NREG);
        n_vec++;
        if (init_done !== minit) begin
            n_miss++;
            $display("FAIL init_done got %b exp %b t=%0t", init_done, minit, $time);
        end
        for (int i = 0; i < NRP; i++) begin
            ca = rd_addr[i*AW +: AW];
            ed = '0;
            eb = 1'b0;
            if (mrun && ca != 0) begin
                if (BYP && wb_en && wb_addr == ca) begin
                    ed = wb_data;
                end else if (BYP && wa_en && wa_addr == ca) begin
                    ed = wa_data;
                    eb = mbusy[ca];
                end else begin
                    ed = mregs[ca];
                    eb = mbusy[ca];
                end
            end
            n_vec++;
            if (rd_data[i*XLEN +: XLEN] !== ed || rd_busy[i] !== eb) begin
                n_miss++;
                $display("FAIL port%0d addr=%0d got data=%h busy=%b exp data=%h busy=%b t=%0t",
                         i, ca, rd_data[i*XLEN +: XLEN], rd_busy[i], ed, eb, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %h exp %h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0;
        wb_en = 1'b0;
        busy_set_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    initial begin
        // Writes during reset and clear are ignored; init_done timing.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        set_rd(0, 5); set_rd(1, 5);
        repeat (3) next();
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            chk("init_low", XLEN'(init_done), 32'h0);
            next();
        end
        idle();
        @(negedge clk);
        chk("init_high", XLEN'(init_done), 32'h1);
        for (int i = 1; i < NREG; i++) begin
            set_rd(0, i); set_rd(1, NREG - i);
            @(negedge clk);
            chk("cleared", rd_data[XLEN-1:0], 32'h0);
            next();
        end

        // Port A write with same-cycle read.
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h12345678; set_rd(0, 3);
        @(negedge clk);
        chk("wa_same", rd_data[XLEN-1:0], BYP ? 32'h12345678 : 32'h0);
        next(); idle();
        @(negedge clk);
        chk("wa_next", rd_data[XLEN-1:0], 32'h12345678);
        next();

        // Both ports to the same register: port B wins.
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
        next(); idle(); set_rd(0, 7);
        @(negedge clk);
        chk("ab_collide", rd_data[XLEN-1:0], 32'h2222);
        next();

        // Scoreboard set, hold, clear by port B.
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        next(); idle(); set_rd(0, 9);
        repeat (3) begin
            @(negedge clk);
            chk("busy_hold", XLEN'(rd_busy[0]), 32'h1);
            next();
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE;
        @(negedge clk);
        chk("busy_wb", XLEN'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
        chk("data_wb", rd_data[XLEN-1:0], BYP ? 32'hCAFE : 32'h0);
        next(); idle();
        @(negedge clk);
        chk("busy_clr", XLEN'(rd_busy[0]), 32'h0);
        chk("data_cafe", rd_data[XLEN-1:0], 32'hCAFE);
        next();

        // Set and clear on the same register: set wins.
        busy_set_en = 1'b1; busy_set_addr = 5'd4;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
        next(); idle(); set_rd(0, 4);
        @(negedge clk);
        chk("setwin_data", rd_data[XLEN-1:0], 32'h4444);
        chk("setwin_busy", XLEN'(rd_busy[0]), 32'h1);
        next();

        // Register zero ignores writes and busy.
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        busy_set_en = 1'b1; busy_set_addr = 5'd0; set_rd(0, 0);
        @(negedge clk);
        chk("x0_same", rd_data[XLEN-1:0], 32'h0);
        next(); idle();
        @(negedge clk);
        chk("x0_data", rd_data[XLEN-1:0], 32'h0);
        chk("x0_busy", XLEN'(rd_busy[0]), 32'h0);
        next();

        // Mid-run reset repeats the clear sequence.
        set_rd(0, 4); reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", XLEN'(rd_busy[0]), 32'h0);
        next();
        @(negedge clk);
        chk("rst_init", XLEN'(init_done), 32'h0);
        reset = 1'b0;
        repeat (NREG) next();
        @(negedge clk);
        chk("reinit", XLEN'(init_done), 32'h1);
        chk("reinit_x4", rd_data[XLEN-1:0], 32'h0);
        chk("reinit_b4", XLEN'(rd_busy[0]), 32'h0);
        set_rd(0, 3); set_rd(1, 7);
        @(negedge clk);
        chk("reinit_x3", rd_data[XLEN-1:0], 32'h0);
        chk("reinit_x7", rd_data[2*XLEN-1:XLEN], 32'h0);
        next();

        // Randomised traffic with collision-heavy addresses and rare resets.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 999) == 0);
            wa_en         = 1'($urandom_range(0, 1));
            wa_addr       = rnd_addr();
            wa_data       = $urandom;
            wb_en         = 1'($urandom_range(0, 1));
            wb_addr       = rnd_addr();
            wb_data       = $urandom;
            busy_set_en   = ($urandom_range(0, 2) == 0);
            busy_set_addr = rnd_addr();
            for (int p = 0; p < NRP; p++) rd_addr[p*AW +: AW] = rnd_addr();
            next();
        end
        reset = 1'b0; idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/two-read ID/WB register file.
- Serves ID-stage operand reads and WB-stage writes.
- Adds a second write port (port B, for load/peripheral return data), a per-register pending-write scoreboard, and a sequential clear sequence after reset.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers (power of 2, ≥4); AW = $clog2(NREG) is a derived localparam.
- NRP, 2, number of read ports.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sequence has finished; registered
- rd_addr  in  NRP*AW  read addresses; port i is at [i*AW +: AW]
- rd_data  out  NRP*XLEN  read data; port i is at [i*XLEN +: XLEN]; combinational
- rd_busy  out  NRP  read port i's register has a pending write not satisfied this cycle
- wa_en  in  1  write port A enable (ALU writeback)
- wa_addr  in  AW  port A address
- wa_data  in  XLEN  port A data
- wb_en  in  1  write port B enable (load return); also clears the busy bit
- wb_addr  in  AW  port B address
- wb_data  in  XLEN  port B data
- busy_set_en  in  1  mark a register as pending (load issued)
- busy_set_addr  in  AW  register to mark

Behaviour:
- States: INIT, RUN. The state register, clear counter, busy bits and init_done are reset; register storage is not.
- Reset is asserted → state=INIT, clr_cnt=0, busy all 0, init_done=0.
- INIT:
  - Each cycle writes 0 to regs[clr_cnt] and increments clr_cnt.
  - When clr_cnt==NREG-1, the last register is cleared and the state moves to RUN; init_done=1 from the next cycle.
  - INIT lasts exactly NREG cycles after reset deasserts.
- During reset or INIT:
  - rd_data=0 and rd_busy=0 on all ports.
  - wa_en, wb_en and busy_set_en are ignored.
- RUN writes:
  - Port A and port B are applied on the rising edge when enabled and the address is non-zero.
  - wa_addr==wb_addr with both enabled → port B data is stored.
  - Writes to address 0 are discarded.
- RUN reads, per port i, in priority order:
  - addr==0 → 0
  - wb_en && wb_addr==addr → wb_data
  - wa_en && wa_addr==addr → wa_data
  - otherwise regs[addr]
  - The two bypass cases apply only with RF_BYPASS_EN.
- Scoreboard:
  - busy[n] is set on the edge with busy_set_en && busy_set_addr==n, n≠0.
  - busy[n] is cleared on the edge with wb_en && wb_addr==n.
  - Set and clear to the same register in the same cycle → set wins, so the register stays busy.
  - wa_en does not affect busy.
  - busy[0] is constantly 0.
- rd_busy[i] = busy[addr_i] & ~(wb_en && wb_addr==addr_i), where the wb term is present only with RF_BYPASS_EN.
- Reset asserted mid-RUN → returns to INIT next edge; busy clears and the full clear sequence repeats.
- Out-of-range addresses cannot occur, since NREG is a power of 2.

Optional Feature:
- RF_BYPASS_EN defined:
  - Same-cycle write-to-read forwarding as above; port B takes priority over port A.
  - rd_busy is masked by a same-cycle port B write.
- RF_BYPASS_EN undefined:
  - Reads always return regs[addr] (0 for addr 0); a write is visible from the next cycle.
  - rd_busy = busy[addr] unmasked.

Test Plan:
- Write 0xDEADBEEF to x5 via port A during reset release → no effect. init_done rises exactly NREG cycles after reset deasserts. Reads of x1..x31 return 0 after INIT.
- RUN, wa_en=1, wa_addr=3, wa_data=0x12345678, same cycle rd_addr0=3:
  - with bypass, rd_data0=0x12345678 that cycle;
  - without bypass, 0 that cycle, then 0x12345678 the next cycle.
- Same cycle, wa_en/wa_addr=7/0x1111 and wb_en/wb_addr=7/0x2222 → next cycle, reading x7 returns 0x2222.
- busy_set on x9, then wait 3 cycles:
  - rd_busy=1 while x9 is read;
  - wb_en on x9 with 0xCAFE → rd_busy=0 that cycle (bypass build) and rd_data=0xCAFE;
  - busy is clear afterwards.
- Same cycle, busy_set_addr=4 and wb_addr=4 → x4 stores wb_data and busy[4]=1 afterwards.
- Write 0xFFFF to x0 via both ports and set busy on x0 → reading x0 returns 0 with rd_busy=0. Reset asserted mid-RUN → init_done=0, busy cleared, all registers read 0 after re-INIT.
